// File: rtl/ttl_reg_load_arb_pkg.sv
// Shared definitions for the register-bank load arbiter: FSM encoding and the
// width helper used to size select/index fields.
package ttl_reg_load_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ttl_reg_load_arb_pick.sv
// Combinational winner picker: the first active request at or after ptr wins,
// wrapping modulo NREQ. With ptr tied to zero it is plain lowest-index priority.
module ttl_reg_load_arb_pick
    import ttl_reg_load_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDXW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        logic [IDXW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDXW'((32'(ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ttl_reg_load_arbiter.sv
// Arbitrates byte loads onto a bank of active-low-enable octal registers sharing one bus.
// Define REG_LOAD_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module ttl_reg_load_arbiter
    import ttl_reg_load_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREG  = 4,
    localparam int unsigned SELW = clog2(NREG)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*SELW-1:0]  ReqSel,
    input  logic [NREQ*WIDTH-1:0] ReqData,
    output logic [NREQ-1:0]       Gnt,
    output logic [WIDTH-1:0]      BusD,
    output logic [NREG-1:0]       Enable_bar,
    output logic                  Busy
);

    localparam int unsigned IDXW = clog2(NREQ);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]  busd_q, busd_d;
    logic [NREG-1:0]   en_q, en_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q;
    logic              pick_valid;
    logic [IDXW-1:0]   pick_idx;

`ifdef REG_LOAD_ARB_RR_EN
    logic [IDXW-1:0] ptr_q, ptr_d;

    // Pointer advances past the winner at the moment it is latched.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && pick_valid) begin
            ptr_d = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    ttl_reg_load_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (Req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`else
    ttl_reg_load_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (Req),
        .ptr   ('0),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`endif

    // Outputs are computed for the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        sel_d   = sel_q;
        busd_d  = busd_q;
        en_d    = '1;
        gnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SETUP;
                    win_d   = pick_idx;
                    sel_d   = ReqSel[pick_idx * SELW +: SELW];
                    busd_d  = ReqData[pick_idx * WIDTH +: WIDTH];
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                // An out-of-range select matches no register, so nothing strobes.
                for (int r = 0; r < NREG; r++) begin
                    en_d[r] = (sel_q != SELW'(r));
                end
            end
            ST_STROBE: begin
                state_d      = ST_DONE;
                gnt_d[win_q] = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            sel_q   <= '0;
            busd_q  <= '0;
            en_q    <= '1;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
            busd_q  <= busd_d;
            en_q    <= en_d;
            gnt_q   <= gnt_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign Gnt        = gnt_q;
    assign BusD       = busd_q;
    assign Enable_bar = en_q;
    assign Busy       = busy_q;

endmodule

// File: doc/ttl_reg_load_arbiter.md
# ttl_reg_load_arbiter

Arbitrates load requests from several sources onto a bank of octal D registers (74377-style, active-low enable, rising-edge capture) that share one data bus. It picks one requester, drives the shared bus with that requester's byte, and pulses the target register's active-low enable for exactly one clock. It then acknowledges the requester. It sits between the microsequencer/peripheral write sources and the register bank, so at most one register is ever loaded per edge.

## Interface
- WIDTH, 8, data bus width
- NREQ, 4, number of requesters (2..8)
- NREG, 4, number of target registers (2..8); select field width SELW = clog2(NREG)
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Req  in  NREQ  per-requester load request, level
- ReqSel  in  NREQ*SELW  target register index per requester (slice i = requester i)
- ReqData  in  NREQ*WIDTH  byte to load per requester
- Gnt  out  NREQ  one-cycle acknowledge pulse, one-hot or zero
- BusD  out  WIDTH  shared register-bank data bus
- Enable_bar  out  NREG  per-register active-low load enable, at most one bit low
- Busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE; all outputs registered.
- IDLE: if any Req is high, pick a winner, latch its index, ReqSel and ReqData internally, then go to SETUP. Otherwise stay.
- SETUP: BusD = latched data; Enable_bar all high; go to STROBE.
- STROBE: BusD held; Enable_bar[latched sel] low; go to DONE.
- DONE: BusD held; Enable_bar all high; Gnt[winner] high; go to IDLE.
- Requester rule: hold Req, ReqSel and ReqData stable until Gnt is seen. Drop Req in the cycle after Gnt, otherwise it is taken as a new request. Changes to ReqSel/ReqData after the IDLE->SETUP edge have no effect.
- Out-of-range ReqSel (>= NREG): the transaction runs normally, but no Enable_bar bit goes low. Gnt still pulses.
- Winner selection is set by the configuration macro (see Configuration).

## Timing
- Reset values: state IDLE, BusD 0, Enable_bar all ones, Gnt 0, Busy 0, round-robin pointer 0.
- Reset mid-transaction: all outputs return to reset values asynchronously. A pending load is abandoned with no Gnt, and a strobe in progress is deasserted at once.
- Req sampled high at edge k (state IDLE) gives:
  - SETUP in cycle k+1;
  - Enable_bar low for cycle k+2 only, so the register captures BusD at edge k+3;
  - Gnt high in cycle k+3;
  - IDLE in cycle k+4.
- Throughput: one load per 4 cycles. Back-to-back grants to different requesters have no dead cycle beyond IDLE.
- BusD is stable from SETUP through DONE. This gives one cycle of setup and one of hold around the capturing edge.
- BusD keeps the last value after DONE until the next SETUP. It does not return to 0.

## Configuration
- REG_LOAD_ARB_RR_EN defined: round-robin arbitration.
  - A pointer P names the highest-priority requester; priority runs P, P+1, ... modulo NREQ.
  - At the winner latch, P is set to winner+1 modulo NREQ.
- REG_LOAD_ARB_RR_EN undefined: fixed priority, lowest index wins. The pointer logic is not compiled.

## Structure
- Shared package/header ttl_reg_load_arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_SETUP=2'd1, ST_STROBE=2'd2, ST_DONE=2'd3;
  - the clog2 helper used for SELW.
- One sub-module, ttl_reg_load_arb_pick: combinational winner picker.
  - Inputs: Req vector, pointer.
  - Outputs: valid flag, winner index.
  - It is instantiated with or without the pointer, according to REG_LOAD_ARB_RR_EN.
- Top level holds the FSM, latches, output registers and pointer.

## Test plan
- Single load: Req[2]=1, ReqSel[2]=3, ReqData[2]=8'hA5 at edge 0 -> Enable_bar=4'b0111 in cycle 2 only, BusD=8'hA5 cycles 1-3, Gnt=4'b0100 in cycle 3, Busy low cycle 4.
- Contention, round-robin: Req=4'b1111 held (each requester drops after its own Gnt) -> Gnt order 0,1,2,3. Under fixed priority, same stimulus -> order 0,1,2,3 as well. Re-asserting Req[0] during requester 1's grant gives order 0,1,0 (fixed) versus 0,1,2 (RR).
- Data latch: change ReqData[1] from 8'h11 to 8'h22 in cycle 1 of its transaction -> BusD stays 8'h11 through DONE, and the register loads 8'h11.
- Out-of-range select: NREG=3, ReqSel=2'd3 -> Enable_bar stays 3'b111 for the whole transaction, and Gnt still pulses in cycle 3.
- Reset mid-op: assert Reset during STROBE -> Enable_bar all ones, Gnt 0, BusD 0 before the next edge. After release, no Gnt appears for the abandoned request unless Req is still high, in which case it starts a fresh SETUP.
- Strobe exclusivity: random Req/ReqSel over 10k cycles -> never more than one Enable_bar bit low, and never more than one Gnt bit high.
